// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller sitting behind the load-use hazard detector.
// Turns ral_hazard, taken-branch pulses and data-memory busy into PC / IF-ID
// enables, IF/ID flush, ID/EX bubble and EX/MEM hold. Load-use stalls are
// limited to one cycle, branch flushes span FLUSH_CYCLES, and a branch seen
// while memory is busy is remembered until the pipeline can act on it.
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES   = 2,
  parameter int STARTUP_CYCLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ral_hazard,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int SU_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [SU_W-1:0] SU_RELOAD    = SU_W'(STARTUP_CYCLES);

  state_t          state, state_nxt;
  logic            flush_pending, pending_nxt;
  logic [FC_W-1:0] flush_rem, rem_nxt;
  logic [SU_W-1:0] su_cnt;
  logic            startup_mask;
  logic            flush_apply;
  logic            pc_w, ifw, flsh, bub, hold;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign startup_mask = (su_cnt != '0);

  // Priority decision: memory freeze, then branch flush, then load-use stall.
  always_comb begin
    state_nxt   = state;
    pending_nxt = flush_pending;
    rem_nxt     = flush_rem;
    flush_apply = 1'b0;
    pc_w        = 1'b1;
    ifw         = 1'b1;
    flsh        = 1'b0;
    bub         = 1'b0;
    hold        = 1'b0;
    if (mem_busy) begin
      // Freeze everything; a flush in progress keeps its remaining count.
      pc_w        = 1'b0;
      ifw         = 1'b0;
      hold        = 1'b1;
      pending_nxt = flush_pending | branch_taken;
      if (state != ST_FLUSH) state_nxt = ST_MEM_WAIT;
    end else if (branch_taken || flush_pending) begin
      // New (or deferred) branch: start or restart the flush window.
      ifw         = 1'b0;
      flsh        = 1'b1;
      bub         = 1'b1;
      flush_apply = 1'b1;
      pending_nxt = 1'b0;
      rem_nxt     = FLUSH_RELOAD;
      state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (state == ST_FLUSH) begin
      ifw       = 1'b0;
      flsh      = 1'b1;
      bub       = 1'b1;
      rem_nxt   = flush_rem - 1'b1;
      state_nxt = (flush_rem == FC_W'(1)) ? ST_RUN : ST_FLUSH;
    end else if (ral_hazard && !startup_mask && state != ST_LU_STALL) begin
      // A stall is never followed by another, so the load always retires.
      pc_w      = 1'b0;
      ifw       = 1'b0;
      bub       = 1'b1;
      state_nxt = ST_LU_STALL;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // State, pending flush, startup mask and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      flush_pending <= 1'b0;
      flush_rem     <= '0;
      su_cnt        <= SU_RELOAD;
      stall_count   <= '0;
      flush_count   <= '0;
    end else begin
      state         <= state_nxt;
      flush_pending <= pending_nxt;
      flush_rem     <= rem_nxt;
      if (su_cnt != '0) su_cnt <= su_cnt - 1'b1;
      if (!pc_w) stall_count <= sat_inc(stall_count);
      if (flush_apply) flush_count <= sat_inc(flush_count);
    end
  end

  // While reset is held the pipeline is fully disabled.
  assign pc_write     = rst_n & pc_w;
  assign if_id_write  = rst_n & ifw;
  assign if_id_flush  = rst_n & flsh;
  assign id_ex_bubble = rst_n & bub;
  assign ex_mem_hold  = rst_n & hold;
  assign ctrl_state   = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a driver applies one directed
// vector per cycle and queues its hand-computed response; a monitor pops and
// checks on the falling edge. A second instance with CNT_W=4 shares all
// inputs to exercise counter saturation.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ral_hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count, flush_count;
  logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, ex_mem_hold4;
  logic [1:0]  ctrl_state4;
  logic [3:0]  stall_count4, flush_count4;

  typedef struct {
    string      tag;
    logic [4:0] o;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold}
    logic [1:0] st;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .STARTUP_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ral_hazard(ral_hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
    .ctrl_state(ctrl_state), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .STARTUP_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ral_hazard(ral_hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write4), .if_id_write(if_id_write4),
    .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .ex_mem_hold(ex_mem_hold4),
    .ctrl_state(ctrl_state4), .stall_count(stall_count4), .flush_count(flush_count4)
  );

  // Drive one cycle of inputs just after the rising edge and queue the expectation.
  task automatic cyc(input string tag, input logic rst, input logic ral, input logic br,
                     input logic mb, input logic [4:0] o, input logic [1:0] st,
                     input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    ral_hazard   = ral;
    branch_taken = br;
    mem_busy     = mb;
    e.tag = tag; e.o = o; e.st = st; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  // Monitor: compare combinational outputs and counters mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [4:0] act;
      int s4;
      e   = q.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold};
      s4  = (e.sc > 15) ? 15 : e.sc;
      n_tests++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL %s outputs got %b want %b", e.tag, act, e.o);
      end
      n_tests++;
      if (ctrl_state !== e.st) begin
        n_fail++;
        $display("FAIL %s ctrl_state got %0d want %0d", e.tag, ctrl_state, e.st);
      end
      n_tests++;
      if (int'(stall_count) != e.sc) begin
        n_fail++;
        $display("FAIL %s stall_count got %0d want %0d", e.tag, stall_count, e.sc);
      end
      n_tests++;
      if (int'(flush_count) != e.fc) begin
        n_fail++;
        $display("FAIL %s flush_count got %0d want %0d", e.tag, flush_count, e.fc);
      end
      n_tests++;
      if (int'(stall_count4) != s4) begin
        n_fail++;
        $display("FAIL %s stall_count_w4 got %0d want %0d", e.tag, stall_count4, s4);
      end
    end
  end

  localparam logic [4:0] O_RST = 5'b00000;
  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_LU  = 5'b00010;
  localparam logic [4:0] O_FL  = 5'b10110;
  localparam logic [4:0] O_FZ  = 5'b00001;

  initial begin
    // Reset state
    cyc("reset0", 0, 0, 0, 0, O_RST, 0, 0, 0);
    cyc("reset1", 0, 1, 1, 1, O_RST, 0, 0, 0);
    // 1: hazard masked in first cycle, single stall in the next
    cyc("t1_mask",  1, 1, 0, 0, O_RUN, 0, 0, 0);
    cyc("t1_stall", 1, 1, 0, 0, O_LU,  0, 0, 0);
    cyc("t1_lu",    1, 0, 0, 0, O_RUN, 1, 1, 0);
    cyc("t1_run",   1, 0, 0, 0, O_RUN, 0, 1, 0);
    // 2: hazard held 4 cycles -> stall, go, stall, go
    cyc("t2_c0", 1, 1, 0, 0, O_LU,  0, 1, 0);
    cyc("t2_c1", 1, 1, 0, 0, O_RUN, 1, 2, 0);
    cyc("t2_c2", 1, 1, 0, 0, O_LU,  0, 2, 0);
    cyc("t2_c3", 1, 1, 0, 0, O_RUN, 1, 3, 0);
    cyc("t2_end", 1, 0, 0, 0, O_RUN, 0, 3, 0);
    // 3: branch and hazard together -> flush wins, two flush cycles
    cyc("t3_rst", 0, 0, 0, 0, O_RST, 0, 0, 0);
    cyc("t3_rel", 1, 0, 0, 0, O_RUN, 0, 0, 0);
    cyc("t3_br",  1, 1, 1, 0, O_FL,  0, 0, 0);
    cyc("t3_fl2", 1, 1, 0, 0, O_FL,  3, 0, 1);
    cyc("t3_run", 1, 0, 0, 0, O_RUN, 0, 0, 1);
    // 3b: branch restarts a flush; memory busy freezes it mid-window
    cyc("t3b_br1",  1, 0, 1, 0, O_FL,  0, 0, 1);
    cyc("t3b_br2",  1, 0, 1, 0, O_FL,  3, 0, 2);
    cyc("t3b_busy", 1, 0, 0, 1, O_FZ,  3, 0, 3);
    cyc("t3b_fl",   1, 0, 0, 0, O_FL,  3, 1, 3);
    cyc("t3b_run",  1, 0, 0, 0, O_RUN, 0, 1, 3);
    // 4: memory busy 3 cycles, branch in the second -> deferred flush
    cyc("t4_rst", 0, 0, 0, 0, O_RST, 0, 0, 0);
    cyc("t4_rel", 1, 0, 0, 0, O_RUN, 0, 0, 0);
    cyc("t4_b0",  1, 0, 0, 1, O_FZ,  0, 0, 0);
    cyc("t4_b1",  1, 0, 1, 1, O_FZ,  2, 1, 0);
    cyc("t4_b2",  1, 0, 0, 1, O_FZ,  2, 2, 0);
    cyc("t4_fl1", 1, 0, 0, 0, O_FL,  2, 3, 0);
    cyc("t4_fl2", 1, 0, 0, 0, O_FL,  3, 3, 1);
    cyc("t4_run", 1, 0, 0, 0, O_RUN, 0, 3, 1);
    // 5: reset during flush, and reset with a pending flush
    cyc("t5_br",   1, 0, 1, 0, O_FL,  0, 3, 1);
    cyc("t5_rst",  0, 0, 0, 0, O_RST, 0, 0, 0);
    cyc("t5_rel",  1, 1, 0, 0, O_RUN, 0, 0, 0);
    cyc("t5_idle", 1, 0, 0, 0, O_RUN, 0, 0, 0);
    cyc("t5_pend", 1, 0, 1, 1, O_FZ,  0, 0, 0);
    cyc("t5_rst2", 0, 0, 0, 0, O_RST, 0, 0, 0);
    cyc("t5_rel2", 1, 0, 0, 0, O_RUN, 0, 0, 0);
    cyc("t5_nofl", 1, 0, 0, 0, O_RUN, 0, 0, 0);
    // 6: memory busy 20 cycles -> narrow counter saturates at 15
    for (int k = 0; k < 20; k++)
      cyc("t6_busy", 1, 0, 0, 1, O_FZ, (k == 0) ? 2'd0 : 2'd2, k, 0);
    cyc("t6_exit", 1, 0, 0, 0, O_RUN, 2, 20, 0);
    cyc("t6_run",  1, 0, 0, 0, O_RUN, 0, 20, 0);
    repeat (3) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue_left got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
